tic_tac_toe_auto_player: RTL
============================

// Module: tic_tac_toe_auto_player
// PURPOSE
//  Computer opponent for tic_tac_toe. It reads the board LED codes and turn/win flags, picks a
//  cell and drives a one-hot button pulse back into the game's a..i inputs. It drives the
//  buttons that the game block samples, i.e. it is the other end of the game's button/LED interface.
// PARAMETERS
//  PULSE_CYCLES  4      cycles press[] is held high per move (>=1)
//  ACK_TIMEOUT   16     cycles to wait for my_turn to drop after pulse ends (>=1)
//  ME            2'b10  LED code of the cells this player owns
//  OPP           2'b01  LED code of the opponent; 2'b00 = empty; 2'b11 = occupied, matches neither
//  AUTO_PLAY     0      1: trigger on my_turn level; 0: trigger on comp_button rising edge
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high
//  comp_button  in   1   request a move (rising edge detected internally; ignored if AUTO_PLAY)
//  my_turn      in   1   game's turn flag for this player (p2_turn)
//  game_over    in   1   p1_win | p2_win | grid_full
//  cells        in   18  LED codes: a=[1:0], b=[3:2] ... i=[17:16]
//  press        out  9   one-hot button drive: bit0=a ... bit8=i
//  busy         out  1   high in every state except IDLE
//  no_move      out  1   1-cycle pulse: triggered but no empty cell
//  ack_timeout  out  1   1-cycle pulse: game did not accept the move
//  last_cell    out  4   index 0..8 of last pressed cell; 4'hF = none
// BEHAVIOUR
//  Reset (async): state IDLE; press=0, busy=0, no_move=0, ack_timeout=0, last_cell=4'hF;
//   button edge-detect register cleared; all outputs registered.
//  trigger = my_turn & ~game_over & (AUTO_PLAY ? 1 : comp_button rise); sampled in IDLE only.
//  States: IDLE, SNAP, WIN, BLOCK, PREF, PRESS, WAIT_ACK.
//  Edge E0 samples trigger: IDLE->SNAP. E1 copies cells into snapshot: SNAP->WIN, line k=0.
//   The scan uses only the snapshot; cells changes after E1 are ignored until WAIT_ACK.
//  Lines k=0..7: abc, def, ghi, adg, beh, cfi, aei, ceg. One line is evaluated per cycle.
//  WIN: at edge E(2+k), if line k has two ME and one empty, go to PRESS on that empty cell.
//   After k=7 misses, go to BLOCK with k=0.
//  BLOCK: same test with OPP at edge E(10+k). After a miss on k=7, go to PREF.
//  PREF at E18: e if empty, else the first empty of a,c,g,i, else the first empty of b,d,f,h.
//   If no cell is empty: pulse no_move and return to IDLE.
//  Press timing: entering PRESS sets press[cell]=1 on the same edge, i.e. after E(2+k) for a win,
//   E(10+k) for a block, E18 for PREF. press is held exactly PULSE_CYCLES cycles, then cleared.
//   last_cell is updated when press rises.
//  Abort: in SNAP/WIN/BLOCK/PREF, if my_turn=0 or game_over=1, return to IDLE with press never
//   asserted and no pulses. A started PRESS pulse is always completed.
//  WAIT_ACK: return to IDLE on the first cycle my_turn=0.
//   After ACK_TIMEOUT cycles with my_turn=1, pulse ack_timeout and return to IDLE.
//  Re-trigger: no re-trigger in the same cycle as the return to IDLE; the earliest new trigger
//   is sampled the following cycle. With AUTO_PLAY=1, a timed-out move retries automatically.
//  comp_button rises while busy=1: the rise is ignored, not queued.
//  press is never multi-hot. press never selects a snapshot cell that was non-empty.
//  Reset mid-operation: all outputs return to their reset values immediately.
// TESTING
//  T1 reset held -> press=0, busy=0, no_move=0, ack_timeout=0, last_cell=F; release with no
//     trigger -> stays IDLE.
//  T2 a=b=ME, d=e=OPP, rest empty; my_turn=1; comp_button rise at E0 -> press=9'h004 after E2,
//     held 4 cycles, last_cell=2; drop my_turn -> IDLE, busy=0.
//  T3 d=e=OPP, a=ME, rest empty -> no win; block on line 1 -> press=9'h020 after E11, last_cell=5.
//  T4 empty board -> press=9'h010 after E18. e=OPP only -> press=9'h001 (corner a).
//  T5 board full with 11/ME/OPP and no line winnable, trigger -> no_move pulses 1 cycle at E18,
//     press stays 0.
//  T6 my_turn held 1 after pulse -> ack_timeout pulses 16 cycles after press falls.
//     reset asserted at E5 of a scan -> press=0, busy=0 at once.
//     my_turn=0 during WIN -> IDLE, no press.

Source files
------------

// File: rtl/tic_tac_toe_auto_player_if.sv
// Button/LED link between the tic_tac_toe game (master) and the auto player (slave).
// Handshake: one move = trigger in IDLE, one-hot press[] held for a fixed pulse, then my_turn falling acks it.
interface tic_tac_toe_auto_player_if;
  logic        comp_button;
  logic        my_turn;
  logic        game_over;
  logic [17:0] cells;
  logic [8:0]  press;
  logic        busy;
  logic        no_move;
  logic        ack_timeout;
  logic [3:0]  last_cell;
  logic [2:0]  state_dbg;

  modport master (
    output comp_button, my_turn, game_over, cells,
    input  press, busy, no_move, ack_timeout, last_cell, state_dbg
  );

  modport slave (
    input  comp_button, my_turn, game_over, cells,
    output press, busy, no_move, ack_timeout, last_cell, state_dbg
  );
endinterface

// File: rtl/tic_tac_toe_auto_player.sv
// Computer opponent: snapshots the board, scans for a win, then a block, then a preferred
// cell, and drives a one-hot button pulse back into the game.
module tic_tac_toe_auto_player #(
  parameter int          PULSE_CYCLES = 4,
  parameter int          ACK_TIMEOUT  = 16,
  parameter logic [1:0]  ME           = 2'b10,
  parameter logic [1:0]  OPP          = 2'b01,
  parameter int          AUTO_PLAY    = 0
) (
  input logic                          clk,
  input logic                          reset,
  tic_tac_toe_auto_player_if.slave     io
);
  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_WIN, S_BLOCK, S_PREF, S_PRESS, S_WAIT_ACK
  } state_t;

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);
  // Centre first, then corners, then edges; lowest index in this list wins.
  localparam logic [3:0] PREF_ORDER [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [15:0] cnt_q, cnt_d;
  logic [17:0] snap_q, snap_d;
  logic [8:0]  press_q, press_d;
  logic [3:0]  last_q, last_d;
  logic        busy_q, busy_d;
  logic        no_move_q, no_move_d;
  logic        ack_q, ack_d;
  logic        btn_q, btn_d;

  logic [1:0]  sc [9];
  logic [3:0]  la, lb, lc;
  logic [1:0]  tgt;
  logic        hit, pref_ok, go_press, abort, trigger;
  logic [3:0]  hit_cell, pref_cell, cell_sel;

  always_comb begin
    for (int i = 0; i < 9; i++) sc[i] = snap_q[2*i +: 2];
  end

  always_comb begin
    la = 4'd0; lb = 4'd1; lc = 4'd2;
    case (k_q)
      3'd0: begin la = 4'd0; lb = 4'd1; lc = 4'd2; end
      3'd1: begin la = 4'd3; lb = 4'd4; lc = 4'd5; end
      3'd2: begin la = 4'd6; lb = 4'd7; lc = 4'd8; end
      3'd3: begin la = 4'd0; lb = 4'd3; lc = 4'd6; end
      3'd4: begin la = 4'd1; lb = 4'd4; lc = 4'd7; end
      3'd5: begin la = 4'd2; lb = 4'd5; lc = 4'd8; end
      3'd6: begin la = 4'd0; lb = 4'd4; lc = 4'd8; end
      default: begin la = 4'd2; lb = 4'd4; lc = 4'd6; end
    endcase
  end

  always_comb begin
    tgt      = (state_q == S_WIN) ? ME : OPP;
    hit      = 1'b0;
    hit_cell = 4'd0;
    if (sc[la] == tgt && sc[lb] == tgt && sc[lc] == 2'b00) begin
      hit = 1'b1; hit_cell = lc;
    end else if (sc[la] == tgt && sc[lc] == tgt && sc[lb] == 2'b00) begin
      hit = 1'b1; hit_cell = lb;
    end else if (sc[lb] == tgt && sc[lc] == tgt && sc[la] == 2'b00) begin
      hit = 1'b1; hit_cell = la;
    end
    pref_ok   = 1'b0;
    pref_cell = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (sc[PREF_ORDER[i]] == 2'b00) begin
        pref_ok   = 1'b1;
        pref_cell = PREF_ORDER[i];
      end
    end
  end

  assign abort   = ~io.my_turn | io.game_over;
  assign trigger = io.my_turn & ~io.game_over &
                   ((AUTO_PLAY != 0) ? 1'b1 : (io.comp_button & ~btn_q));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    press_d   = press_q;
    last_d    = last_q;
    no_move_d = 1'b0;
    ack_d     = 1'b0;
    btn_d     = io.comp_button;
    go_press  = 1'b0;
    cell_sel  = 4'd0;
    case (state_q)
      S_IDLE: if (trigger) state_d = S_SNAP;
      S_SNAP: begin
        if (abort) state_d = S_IDLE;
        else begin
          snap_d  = io.cells;
          k_d     = 3'd0;
          state_d = S_WIN;
        end
      end
      S_WIN, S_BLOCK: begin
        if (abort) state_d = S_IDLE;
        else if (hit) begin
          go_press = 1'b1;
          cell_sel = hit_cell;
        end else if (k_q == 3'd7) begin
          k_d     = 3'd0;
          state_d = (state_q == S_WIN) ? S_BLOCK : S_PREF;
        end else k_d = k_q + 3'd1;
      end
      S_PREF: begin
        if (abort) state_d = S_IDLE;
        else if (pref_ok) begin
          go_press = 1'b1;
          cell_sel = pref_cell;
        end else begin
          no_move_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_PRESS: begin
        // The pulse always runs to completion, whatever my_turn does meanwhile.
        if (cnt_q == PULSE_LAST) begin
          press_d = 9'd0;
          cnt_d   = 16'd0;
          state_d = S_WAIT_ACK;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_WAIT_ACK: begin
        if (!io.my_turn) state_d = S_IDLE;
        else if (cnt_q == ACK_LAST) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (go_press) begin
      press_d = 9'b1 << cell_sel;
      last_d  = cell_sel;
      cnt_d   = 16'd0;
      state_d = S_PRESS;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= 3'd0;
      cnt_q     <= 16'd0;
      snap_q    <= 18'd0;
      press_q   <= 9'd0;
      last_q    <= 4'hF;
      busy_q    <= 1'b0;
      no_move_q <= 1'b0;
      ack_q     <= 1'b0;
      btn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      press_q   <= press_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      no_move_q <= no_move_d;
      ack_q     <= ack_d;
      btn_q     <= btn_d;
    end
  end

  assign io.press       = press_q;
  assign io.busy        = busy_q;
  assign io.no_move     = no_move_q;
  assign io.ack_timeout = ack_q;
  assign io.last_cell   = last_q;
  assign io.state_dbg   = state_q;
endmodule
